// File: rtl/ttt_pkg.sv
// Shared types and defaults for the tick-tock-tokens event FIFO slice.
package ttt_pkg;

  localparam int DFLT_TS_BITS   = 6;
  localparam int DFLT_DATA_BITS = DFLT_TS_BITS + 2;
  localparam int DFLT_DEPTH     = 8;

  typedef struct packed {
    logic [DFLT_TS_BITS-1:0] ts;
    logic                    start;
    logic                    stop;
  } event_t;

  // Flags 2'b00 never occur on a real event, so this word is unambiguous.
  localparam event_t WRAP_MARKER = '{ts: '0, start: 1'b0, stop: 1'b0};

endpackage

// File: rtl/ttt_event_fifo_if.sv
// Flag input and host drain bus of the event FIFO.
interface ttt_event_fifo_if #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 8
);
  localparam int LVL_BITS = $clog2(DEPTH) + 1;

  logic                 flags_valid;
  logic                 token_start;
  logic                 token_stop;
  logic [DATA_BITS-1:0] event_data;
  logic                 event_valid;
  logic                 event_ready;
  logic [LVL_BITS-1:0]  fill_level;
  logic                 overflow;
  logic                 clear_ovf;

  modport master (
    output flags_valid, token_start, token_stop, event_ready, clear_ovf,
    input  event_data, event_valid, fill_level, overflow
  );

  modport slave (
    input  flags_valid, token_start, token_stop, event_ready, clear_ovf,
    output event_data, event_valid, fill_level, overflow
  );
endinterface

// File: rtl/ttt_sync_fifo.sv
// First-word-fall-through synchronous FIFO; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module ttt_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int ADDR_BITS = $clog2(DEPTH);
  localparam int LVL_BITS  = ADDR_BITS + 1;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic [LVL_BITS-1:0]  count_q;
  logic                 do_push;
  logic                 do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == LVL_BITS'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/ttt_event_fifo.sv
// Timestamps token start/stop flags with a local tick counter and buffers them,
// plus coalesced counter-wrap markers, for the host to drain.
module ttt_event_fifo
  import ttt_pkg::*;
#(
  parameter int DATA_BITS = DFLT_DATA_BITS,
  parameter int TS_BITS   = DFLT_TS_BITS,
  parameter int DEPTH     = DFLT_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              tick,
  ttt_event_fifo_if.slave   bus
);
  localparam int LVL_BITS = $clog2(DEPTH) + 1;
  localparam logic [DATA_BITS-1:0] WRAP_WORD = DATA_BITS'(WRAP_MARKER);

  logic [TS_BITS-1:0]   ts_q;
  logic                 wrap_pending_q;
  logic                 overflow_q;
  logic                 ev_push;
  logic                 wrap_push;
  logic                 push;
  logic                 pop;
  logic                 drop;
  logic                 wrap_now;
  logic                 full;
  logic                 empty;
  logic [DATA_BITS-1:0] push_word;
  logic [DATA_BITS-1:0] head_word;
  logic [LVL_BITS-1:0]  count;

  assign ev_push   = ena && bus.flags_valid && (bus.token_start || bus.token_stop);
  assign wrap_push = ena && wrap_pending_q && !ev_push;
  assign push      = ev_push || wrap_push;
  assign push_word = ev_push ? {ts_q, bus.token_start, bus.token_stop} : WRAP_WORD;
  assign pop       = !empty && bus.event_ready;
  assign drop      = push && full && !pop;
  assign wrap_now  = ena && tick && (ts_q == {TS_BITS{1'b1}});

  ttt_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (push_word),
    .pop   (pop),
    .rdata (head_word),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // A wrap in the same cycle a marker leaves keeps the flag set for the next one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts_q           <= '0;
      wrap_pending_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      if (ena && tick) ts_q <= ts_q + 1'b1;
      if (wrap_now)       wrap_pending_q <= 1'b1;
      else if (wrap_push) wrap_pending_q <= 1'b0;
      if (drop)               overflow_q <= 1'b1;
      else if (bus.clear_ovf) overflow_q <= 1'b0;
    end
  end

  assign bus.event_valid = !empty;
  assign bus.event_data  = empty ? '0 : head_word;
  assign bus.fill_level  = count;
  assign bus.overflow    = overflow_q;

endmodule
